// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
//
// This block shares the two data-memory ports among the four M-stage lanes of
// the four-issue pipeline. In each cycle it grants up to two pending lane
// requests in lane order:
//   - the lowest pending lane goes to port 0;
//   - the next pending lane goes to port 1.
// Load data for each lane is held in a register until the whole bundle has
// been served. stallM_all stays high until every request in the bundle has
// been granted, and the earlier pipeline stages OR it into their stalls.
//
// Ports
//   clk, reset                   clock and asynchronous active-high reset
//   memtoregM..M4                lane k has a load in M
//   memwriteM..M4                lane k has a store in M (drives we)
//   aluoutM..M4                  lane k byte address
//   writedataM..M4               lane k store data
//   rdata0 / rdata1              combinational read data from port 0 / port 1
//   en0/we0/addr0/wdata0         port 0 controls (all zero when unused)
//   en1/we1/addr1/wdata1         port 1 controls (all zero when unused)
//   readdataM..M4                per-lane load result
//   memstallM3 / memstallM4      lane 3 / lane 4 still unserved after this cycle
//   stallM_all                   bundle still has unserved requests
// ----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memtoregM,
    input  logic          memtoregM2,
    input  logic          memtoregM3,
    input  logic          memtoregM4,
    input  logic          memwriteM,
    input  logic          memwriteM2,
    input  logic          memwriteM3,
    input  logic          memwriteM4,
    input  logic [AW-1:0] aluoutM,
    input  logic [AW-1:0] aluoutM2,
    input  logic [AW-1:0] aluoutM3,
    input  logic [AW-1:0] aluoutM4,
    input  logic [DW-1:0] writedataM,
    input  logic [DW-1:0] writedataM2,
    input  logic [DW-1:0] writedataM3,
    input  logic [DW-1:0] writedataM4,
    input  logic [DW-1:0] rdata0,
    input  logic [DW-1:0] rdata1,
    output logic          we0,
    output logic          we1,
    output logic          en0,
    output logic          en1,
    output logic [AW-1:0] addr0,
    output logic [AW-1:0] addr1,
    output logic [DW-1:0] wdata0,
    output logic [DW-1:0] wdata1,
    output logic [DW-1:0] readdataM,
    output logic [DW-1:0] readdataM2,
    output logic [DW-1:0] readdataM3,
    output logic [DW-1:0] readdataM4,
    output logic          memstallM3,
    output logic          memstallM4,
    output logic          stallM_all
);

    logic [3:0]    ld;
    logic [3:0]    st;
    logic [3:0]    req;
    logic [3:0]    pending;
    logic [3:0]    gnt;
    logic [3:0]    served_q;
    logic [3:0]    served_d;
    logic [AW-1:0] lane_addr [4];
    logic [DW-1:0] lane_wdata[4];
    logic [DW-1:0] hold_q    [4];
    logic [DW-1:0] hold_d    [4];
    logic [DW-1:0] lane_rd   [4];
    logic [DW-1:0] port_data;
    logic [1:0]    g1;
    logic [1:0]    g2;
    logic          g1_vld;
    logic          g2_vld;
    logic          g2_ok;

    // Gather the per-lane inputs into arrays so that lanes can be indexed.
    always_comb begin
        ld = {memtoregM4, memtoregM3, memtoregM2, memtoregM};
        st = {memwriteM4, memwriteM3, memwriteM2, memwriteM};
        lane_addr[0]  = aluoutM;
        lane_addr[1]  = aluoutM2;
        lane_addr[2]  = aluoutM3;
        lane_addr[3]  = aluoutM4;
        lane_wdata[0] = writedataM;
        lane_wdata[1] = writedataM2;
        lane_wdata[2] = writedataM3;
        lane_wdata[3] = writedataM4;
    end

    // Grant selection.
    always_comb begin
        req = ld | st;
        // While reset is asserted, nothing is pending. The ports and the
        // stalls therefore drop to zero at once.
        pending = req & ~served_q & {4{~reset}};
        g1     = 2'd0;
        g2     = 2'd0;
        g1_vld = 1'b0;
        g2_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (pending[k]) begin
                if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1     = 2'(k);
                end else if (!g2_vld) begin
                    g2_vld = 1'b1;
                    g2     = 2'(k);
                end
            end
        end
        // If both grants hit the same word and either one writes, the
        // second lane waits. Lane order is then kept for RAW/WAR/WAW to
        // that word.
        g2_ok = g2_vld;
        if (g1_vld && g2_vld &&
            (lane_addr[g1][AW-1:2] == lane_addr[g2][AW-1:2]) &&
            (st[g1] || st[g2])) begin
            g2_ok = 1'b0;
        end
        gnt = 4'b0000;
        if (g1_vld) gnt[g1] = 1'b1;
        if (g2_ok)  gnt[g2] = 1'b1;
    end

    // Port drive, stalls and next served mask.
    always_comb begin
        en0    = g1_vld;
        we0    = g1_vld & st[g1];
        addr0  = g1_vld ? lane_addr[g1]  : '0;
        wdata0 = g1_vld ? lane_wdata[g1] : '0;
        en1    = g2_ok;
        we1    = g2_ok & st[g2];
        addr1  = g2_ok ? lane_addr[g2]  : '0;
        wdata1 = g2_ok ? lane_wdata[g2] : '0;

        stallM_all = |(pending & ~gnt);
        memstallM3 = pending[2] & ~gnt[2];
        memstallM4 = pending[3] & ~gnt[3];

        // The served mask is cleared on the last cycle of a bundle, so the
        // next bundle starts fresh.
        served_d = stallM_all ? (served_q | gnt) : 4'b0000;
    end

    // Per-lane load data: a granted lane sees its port live. Any other lane
    // sees the value captured when it was granted.
    always_comb begin
        port_data = '0;
        for (int k = 0; k < 4; k++) begin
            port_data  = (g2_ok && (g2 == 2'(k))) ? rdata1 : rdata0;
            lane_rd[k] = gnt[k] ? port_data : hold_q[k];
            hold_d[k]  = (gnt[k] && ld[k]) ? port_data : hold_q[k];
        end
    end

    assign readdataM  = lane_rd[0];
    assign readdataM2 = lane_rd[1];
    assign readdataM3 = lane_rd[2];
    assign readdataM4 = lane_rd[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            served_q <= 4'b0000;
            for (int k = 0; k < 4; k++) hold_q[k] <= '0;
        end else begin
            served_q <= served_d;
            for (int k = 0; k < 4; k++) hold_q[k] <= hold_d[k];
        end
    end

endmodule
